mips_instr_encoder: RTL
=======================

# mips_instr_encoder

- Converts a stream of decoded instruction descriptors (mnemonic kind plus register and immediate fields) back into 32-bit MIPS machine words.
- Writes the words out with a program-memory word address, so a bench or boot loader can build instruction memory contents.
- Covers exactly the opcode set the processor's control unit decodes: R-type, ADDI, ORI, ANDI, LUI, LW, BNE, BEQ.
- Has an input valid/ready handshake, a 2-entry output FIFO and a wrapping address counter.

## Interface
- ADDR_WIDTH, 8, width of the output word address and address counter.
- START_ADDR, 0, address loaded into the counter at reset.
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low reset; sampled on the rising edge of clk.
- in_valid  in  1  descriptor present on the in_* fields.
- in_ready  out  1  encoder can accept a descriptor this cycle.
- in_kind  in  4  0 R_TYPE, 1 ADDI, 2 ORI, 3 ANDI, 4 LUI, 5 LW, 6 BNE, 7 BEQ, 8 NOP (see Configuration); all other values are illegal.
- in_rs, in_rt, in_rd, in_shamt  in  5 each  register and shift-amount fields.
- in_funct  in  6  R-type function field.
- in_imm  in  16  immediate or branch offset, used raw (no sign handling).
- out_valid  out  1  FIFO head holds a word.
- out_ready  in  1  consumer takes the head word this cycle.
- out_instr  out  32  encoded word at the FIFO head; 0 when the FIFO is empty.
- out_addr  out  ADDR_WIDTH  address for out_instr, equal to the address counter.
- err_illegal  out  1  sticky; set when an illegal kind is accepted.
- illegal_count  out  8  saturating count of illegal descriptors (saturates at 255).

## Operation
- Input handshake: a descriptor is accepted when in_valid && in_ready.
  - in_ready = (fifo_count != 2).
  - in_ready is derived from registered state only. There is no combinational path from out_ready.
- Encoding of an accepted descriptor:
  - R_TYPE: {6'h00, rs, rt, rd, shamt, funct}.
  - I-type: {op, rs, rt, imm}, with op = ADDI 6'h08, ORI 6'h0d, ANDI 6'h0c, LUI 6'h0f, LW 6'h23, BNE 6'h05, BEQ 6'h04.
  - LUI: the rs field is forced to 0.
  - For I-types, rd, shamt and funct are ignored.
- FIFO: legal encoded words are pushed into a 2-entry FIFO. Pointers are 1 bit; count is 0..2.
- Illegal kind:
  - The descriptor is still accepted, so the handshake completes.
  - Nothing is pushed and the address does not change.
  - err_illegal is set and illegal_count increments.
- Output handshake: on out_valid && out_ready the head entry is popped and the address counter increments.
  - The counter wraps modulo 2^ADDR_WIDTH; the increment after all-ones is 0.
- Simultaneous push and pop with count 1: count stays 1, the new word becomes the head next cycle, and the address increments.
- Push with count 2 cannot occur, because in_ready is low.
- Pop with count 0 cannot occur, because out_valid is low.
- Reset (reset==0 at a clock edge), including mid-stream:
  - FIFO is emptied and held words are discarded.
  - Address counter loads START_ADDR.
  - err_illegal clears to 0 and illegal_count clears to 0.
  - A handshake in flight during the reset cycle is ignored.
- Reset values of outputs: in_ready=1, out_valid=0, out_instr=0, out_addr=START_ADDR, err_illegal=0, illegal_count=0.

## Timing
- Latency: a descriptor accepted at edge N appears with out_valid=1 after edge N, when the FIFO was empty or popped at edge N.
- Throughput: 1 word/cycle while out_ready is held high.
- out_instr and out_addr are held stable while out_valid && !out_ready.
- When out_ready is held low, two words are accepted, then in_ready drops on the following cycle.
- in_ready rises one cycle after the first pop from a full FIFO.
- err_illegal and illegal_count update on the edge after the illegal descriptor is accepted.

## Configuration
- INSTR_ENC_NOP_EN defined: kind 8 (NOP) is legal and encodes to 32'h00000000 (sll $0,$0,0). It is pushed and consumes an address like any other word.
- INSTR_ENC_NOP_EN undefined: kind 8 is illegal, with the drop, err_illegal and illegal_count behaviour above.

## Test plan
- Single words from reset, out_ready=1, START_ADDR=0:
  - ADDI rs=0 rt=8 imm=0x0005 -> 0x20080005 @0.
  - LUI rs=7 rt=1 imm=0x1001 -> 0x3C011001 @1 (rs forced to 0).
- Back-to-back stream:
  - R_TYPE rs=9 rt=10 rd=8 shamt=0 funct=0x20 -> 0x012A4020.
  - BEQ rs=8 rt=9 imm=0xFFFE -> 0x1109FFFE.
  - LW rs=29 rt=4 imm=0x0008 -> 0x8FA40008.
  - Required: consecutive addresses, one word per cycle.
- Backpressure: out_ready=0 and push 3 descriptors -> exactly 2 accepted, then in_ready=0 and outputs stable. Raise out_ready -> words drain in order and the third is accepted after the first pop.
- Illegal and NOP:
  - kind=0xF between two ADDIs -> err_illegal=1, illegal_count=1, and the ADDIs appear at consecutive addresses.
  - kind=8 -> 32'h0 with the macro defined; with it undefined, illegal_count increments instead.
- Wrap: ADDR_WIDTH=2, five legal words -> addresses 0,1,2,3,0.
- Reset mid-stream: FIFO full and err_illegal=1, assert reset for one cycle -> out_valid=0, out_addr=START_ADDR, err_illegal=0, illegal_count=0, in_ready=1 on the next cycle.

Source files
------------

// File: rtl/mips_instr_encoder.sv
// Encodes decoded MIPS descriptors (R-type, ADDI, ORI, ANDI, LUI, LW, BNE, BEQ) into 32-bit words with a word address.
// Latency: one cycle from input handshake to out_valid (word visible after the accepting edge).
// Backpressure: in_ready = FIFO not full (registered state only); INSTR_ENC_NOP_EN makes kind 8 a legal NOP.

module mips_instr_encoder_fifo #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] dat_i,
  output logic         vld_o,
  output logic         rdy_o,
  output logic [W-1:0] dat_o
);
  // Two-entry FIFO, 1-bit pointers; head reads as zero when empty.
  logic [W-1:0] mem_q [2];
  logic         wr_ptr_q, wr_ptr_d;
  logic         rd_ptr_q, rd_ptr_d;
  logic [1:0]   count_q, count_d;
  logic         do_push, do_pop;

  assign rdy_o   = (count_q != 2'd2);
  assign vld_o   = (count_q != 2'd0);
  assign do_push = push_i && rdy_o;
  assign do_pop  = pop_i && vld_o;
  assign dat_o   = vld_o ? mem_q[rd_ptr_q] : '0;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = ~wr_ptr_q;
    if (do_pop)  rd_ptr_d = ~rd_ptr_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= dat_i;
  end
endmodule

module mips_instr_encoder #(
  parameter int ADDR_WIDTH = 8,
  parameter int START_ADDR = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3:0]            in_kind,
  input  logic [4:0]            in_rs,
  input  logic [4:0]            in_rt,
  input  logic [4:0]            in_rd,
  input  logic [4:0]            in_shamt,
  input  logic [5:0]            in_funct,
  input  logic [15:0]           in_imm,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [31:0]           out_instr,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic                  err_illegal,
  output logic [7:0]            illegal_count
);
  typedef enum logic [3:0] {
    K_RTYPE = 4'd0,
    K_ADDI  = 4'd1,
    K_ORI   = 4'd2,
    K_ANDI  = 4'd3,
    K_LUI   = 4'd4,
    K_LW    = 4'd5,
    K_BNE   = 4'd6,
    K_BEQ   = 4'd7,
    K_NOP   = 4'd8
  } kind_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_ANDI  = 6'h0c;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_BEQ   = 6'h04;

  localparam logic [ADDR_WIDTH-1:0] ADDR_RST = ADDR_WIDTH'(START_ADDR);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);

  logic [31:0]           enc_word;
  logic                  enc_legal;
  logic                  accept, push, pop;
  logic                  fifo_rdy, fifo_vld;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  err_q, err_d;
  logic [7:0]            ill_cnt_q, ill_cnt_d;

  always_comb begin
    enc_legal = 1'b1;
    enc_word  = '0;
    case (kind_e'(in_kind))
      K_RTYPE: enc_word = {OP_RTYPE, in_rs, in_rt, in_rd, in_shamt, in_funct};
      K_ADDI:  enc_word = {OP_ADDI, in_rs, in_rt, in_imm};
      K_ORI:   enc_word = {OP_ORI,  in_rs, in_rt, in_imm};
      K_ANDI:  enc_word = {OP_ANDI, in_rs, in_rt, in_imm};
      K_LUI:   enc_word = {OP_LUI,  5'd0,  in_rt, in_imm};
      K_LW:    enc_word = {OP_LW,   in_rs, in_rt, in_imm};
      K_BNE:   enc_word = {OP_BNE,  in_rs, in_rt, in_imm};
      K_BEQ:   enc_word = {OP_BEQ,  in_rs, in_rt, in_imm};
`ifdef INSTR_ENC_NOP_EN
      K_NOP:   enc_word = 32'h0000_0000;
`endif
      default: enc_legal = 1'b0;
    endcase
  end

  assign accept = in_valid && in_ready;
  assign push   = accept && enc_legal;
  assign pop    = out_valid && out_ready;

  mips_instr_encoder_fifo #(.W(32)) u_fifo (
    .clk    (clk),
    .reset  (reset),
    .push_i (push),
    .pop_i  (pop),
    .dat_i  (enc_word),
    .vld_o  (fifo_vld),
    .rdy_o  (fifo_rdy),
    .dat_o  (out_instr)
  );

  assign in_ready  = fifo_rdy;
  assign out_valid = fifo_vld;

  // Illegal descriptors complete the handshake but never consume an address.
  always_comb begin
    addr_d    = addr_q;
    err_d     = err_q;
    ill_cnt_d = ill_cnt_q;
    if (pop) addr_d = addr_q + ADDR_ONE;
    if (accept && !enc_legal) begin
      err_d = 1'b1;
      if (ill_cnt_q != 8'hFF) ill_cnt_d = ill_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      addr_q    <= ADDR_RST;
      err_q     <= 1'b0;
      ill_cnt_q <= 8'd0;
    end else begin
      addr_q    <= addr_d;
      err_q     <= err_d;
      ill_cnt_q <= ill_cnt_d;
    end
  end

  assign out_addr      = addr_q;
  assign err_illegal   = err_q;
  assign illegal_count = ill_cnt_q;
endmodule
